// File: rtl/pc_ctrl.sv
// ---------------------------------------------------------------------------
// pc_ctrl -- program counter and next-PC sequencer for the 8-bit core.
//
// Sits directly after the ALU. Each cycle it picks the next fetch address:
// PC+1, or a branch target read from a small programmable lookup table.
// It also runs the start/halt handshake with the test harness.
//
// Ports:
//   clk           system clock, all state updates on the rising edge
//   rst_n         asynchronous active-low reset
//   start         harness request to begin execution at PC 0
//   stall         hold the current PC (multi-cycle instruction in flight)
//   halt          decoded halt instruction at the current PC
//   branch_en     current instruction is a conditional branch
//   branch_on_nz  0: taken when alu_zero=1, 1: taken when alu_zero=0
//   alu_zero      ALU zero flag for the current instruction
//   lut_idx       branch-target LUT index from the instruction field
//   lut_we        LUT write enable
//   lut_waddr     LUT write address
//   lut_wdata     LUT write data (absolute target PC)
//   pc            current fetch address (registered)
//   branch_taken  branch resolves taken this cycle (combinational)
//   running       registered, high while executing
//   done          registered, high once halted
// ---------------------------------------------------------------------------
module pc_ctrl #(
    parameter int PC_WIDTH = 10,
    parameter int LUT_AW   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stall,
    input  logic                halt,
    input  logic                branch_en,
    input  logic                branch_on_nz,
    input  logic                alu_zero,
    input  logic [LUT_AW-1:0]   lut_idx,
    input  logic                lut_we,
    input  logic [LUT_AW-1:0]   lut_waddr,
    input  logic [PC_WIDTH-1:0] lut_wdata,
    output logic [PC_WIDTH-1:0] pc,
    output logic                branch_taken,
    output logic                running,
    output logic                done
);

    localparam int LUT_DEPTH = 1 << LUT_AW;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALTED
    } state_e;

    state_e                state_q,   state_d;
    logic [PC_WIDTH-1:0]   pc_q,      pc_d;
    logic                  running_q, running_d;
    logic                  done_q,    done_d;
    logic [PC_WIDTH-1:0]   lut_q [LUT_DEPTH];
    logic [PC_WIDTH-1:0]   lut_d [LUT_DEPTH];
    logic [PC_WIDTH-1:0]   lut_rdata;

    // Read comes from the stored array, so a same-edge write to the branch
    // index is not forwarded: the branch sees the old target.
    assign lut_rdata = lut_q[lut_idx];

    assign branch_taken = (state_q == ST_RUN) & ~stall & ~halt & branch_en
                        & (alu_zero ^ branch_on_nz);

    // Next-state and next-PC selection.
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        pc_d    = pc_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
                end
            end
            ST_RUN: begin
                if (stall) begin
                    // Hold everything; halt and branch wait for the stall
                    // to clear.
                end else if (halt) begin
                    // PC stays on the halt instruction.
                    state_d = ST_HALTED;
                end else if (branch_taken) begin
                    pc_d = lut_rdata;
                end else begin
                    // Wraps silently from all-ones to zero.
                    pc_d = pc_q + PC_WIDTH'(1);
                end
            end
            ST_HALTED: begin
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = '0;
            end
        endcase

        // Flags are registered copies of the state so they switch on the
        // same edge as the state itself.
        running_d = (state_d == ST_RUN);
        done_d    = (state_d == ST_HALTED);
    end

    // LUT write path; legal in every state.
    always_comb begin
        lut_d = lut_q;
        if (lut_we) begin
            lut_d[lut_waddr] = lut_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its _d value from before the edge, independent of order.
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            // NOTE: the LUT is built from flops rather than a RAM macro
            // because every entry must read zero straight out of reset.
            for (int i = 0; i < LUT_DEPTH; i++) begin
                lut_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            running_q <= running_d;
            done_q    <= done_d;
            for (int i = 0; i < LUT_DEPTH; i++) begin
                lut_q[i] <= lut_d[i];
            end
        end
    end

    assign pc      = pc_q;
    assign running = running_q;
    assign done    = done_q;

endmodule
